dual_port_ram: RTL and testbench
================================

# dual_port_ram

True dual-port synchronous RAM with two fully independent read/write ports sharing one storage array of 2^widthad words. It is the physical backing store for one page of the paged memory subsystem: the pager instantiates one per page slot. Each port accesses the page through its low address bits, and the pager fills or drains the page through the same ports.

## Interface
Parameters:
- widthad, default 12: address width; depth is 2^widthad words.
- width, default 32: data word width in bits.

Ports:
- clk  input  1  the single clock; all storage and output registers update on its rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- address_a  input  widthad  port A word address.
- wren_a  input  1  port A write enable.
- data_a  input  width  port A write data.
- rden_a  input  1  port A read enable.
- q_a  output  width  port A registered read data.
- address_b, wren_b, data_b, rden_b, q_b: port B equivalents, same widths and meanings.

## Operation
- Storage: array mem[0 .. 2^widthad-1] of width bits, initialised to all zeros at configuration/simulation start. rst_n does not clear the array.
- Write: on a rising clk with wren_x=1, mem[address_x] <= data_x.
- Read: on a rising clk with rden_x=1, q_x <= the contents of mem[address_x] before any write in that same edge. This is read-before-write on both ports.
- With rden_x=0, q_x holds its previous value.
- rden_x and wren_x high together on one port: the write is performed, and q_x returns the old word.
- Cross-port collision, both ports writing the same address on one edge: port A's data is stored and port B's write to that address is discarded.
- Cross-port read/write, one port reading an address the other port writes on the same edge: the reader gets the old word. The new word is visible from the next edge.
- Addresses are always in range; no wrap or bounds logic is needed.
- Enables and data are sampled only at the clock edge. Glitches between edges have no effect.

## Timing
- Read latency is 1 cycle: the address is presented with rden at edge N, and q is valid after edge N and stable until the next edge with rden=1.
- Write latency is 1 cycle: a write at edge N is readable by either port at edge N+1.
- Both ports can perform an independent operation every cycle; throughput is one access per port per cycle.
- Reset:
  - rst_n low forces q_a=0 and q_b=0 immediately, with no clock required.
  - While rst_n is low, writes and reads are ignored.
  - An access presented at the same edge on which rst_n is low is lost.
  - The first edge with rst_n high resumes normal operation.
  - Array contents survive reset.
- No handshake: the block is always ready, and there is no busy or valid output.

## Test plan
- Reset: hold rst_n=0 with rden_a=rden_b=1 and toggle clk -> q_a=q_b=0. Release rst_n and read address 0 -> q_a=0 (power-up contents).
- Basic write/read:
  - A writes 0xDEADBEEF to address 0x005.
  - Next cycle B reads 0x005 -> q_b=0xDEADBEEF one cycle later.
  - A reads 0x005 -> q_a=0xDEADBEEF.
- Hold and independent ports:
  - A reads address 3 (holding 0x11), then drops rden_a while B writes and reads other addresses for 5 cycles -> q_a stays 0x11 throughout.
- Same-port read-during-write: address 7 holds 0xAAAA0000. Set wren_a=rden_a=1 with data 0x12345678 -> q_a=0xAAAA0000, and a subsequent read returns 0x12345678.
- Cross-port collisions:
  - Both ports write address 0xFFF on one edge, A=0x1, B=0x2 -> a subsequent read gives 0x1.
  - A writes 0x9 to address 0x10 while B reads 0x10 (old 0x0) on the same edge -> q_b=0x0, and B reads 0x9 next cycle.
- Async reset mid-operation:
  - Fill address 0x20 with 0x55.
  - Assert rst_n=0 between clock edges -> q outputs clear at once.
  - After release, reading 0x20 -> 0x55 (contents preserved).

Source files
------------

// File: rtl/dual_port_ram.sv
// rtl/dual_port_ram.sv - true dual-port synchronous RAM, read-before-write, port A wins write collisions
module dual_port_ram #(
  parameter int widthad = 12,
  parameter int width   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  // Port A
  input  logic [widthad-1:0] address_a,
  input  logic               wren_a,
  input  logic [width-1:0]   data_a,
  input  logic               rden_a,
  output logic [width-1:0]   q_a,
  // Port B
  input  logic [widthad-1:0] address_b,
  input  logic               wren_b,
  input  logic [width-1:0]   data_b,
  input  logic               rden_b,
  output logic [width-1:0]   q_b
);

  localparam int DEPTH = 1 << widthad;

  // Page storage. Zero at configuration time; reset never touches it.
  logic [width-1:0] r_mem [DEPTH] = '{default: '0};

  logic [width-1:0] r_q_a;
  logic [width-1:0] r_q_b;

  // Gated write strobes. A write at an edge where reset is low is dropped.
  // When both ports hit the same word, port B's write is suppressed so A's data lands.
  logic w_we_a;
  logic w_we_b;
  logic w_same_addr;

  assign w_same_addr = (address_a == address_b);
  assign w_we_a      = rst_n & wren_a;
  assign w_we_b      = rst_n & wren_b & ~(wren_a & w_same_addr);

  // Array update; non-blocking writes keep same-edge readers seeing the old word.
  always_ff @(posedge clk) begin
    if (w_we_b) begin
      r_mem[address_b] <= data_b;
    end
    if (w_we_a) begin
      r_mem[address_a] <= data_a;
    end
  end

  // Port A output register: async clear, load on read enable, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q_a <= '0;
    end else if (rden_a) begin
      r_q_a <= r_mem[address_a];
    end
  end

  // Port B output register: async clear, load on read enable, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q_b <= '0;
    end else if (rden_b) begin
      r_q_b <= r_mem[address_b];
    end
  end

  assign q_a = r_q_a;
  assign q_b = r_q_b;

endmodule

// File: tb/tb_dual_port_ram.sv
// tb/tb_dual_port_ram.sv - directed self-checking bench for dual_port_ram
module tb_dual_port_ram;

  localparam int AW = 12;
  localparam int DW = 32;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] address_a;
  logic          wren_a;
  logic [DW-1:0] data_a;
  logic          rden_a;
  logic [DW-1:0] q_a;
  logic [AW-1:0] address_b;
  logic          wren_b;
  logic [DW-1:0] data_b;
  logic          rden_b;
  logic [DW-1:0] q_b;

  int checks   = 0;
  int failures = 0;

  dual_port_ram #(.widthad(AW), .width(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .address_a (address_a),
    .wren_a    (wren_a),
    .data_a    (data_a),
    .rden_a    (rden_a),
    .q_a       (q_a),
    .address_b (address_b),
    .wren_b    (wren_b),
    .data_b    (data_b),
    .rden_b    (rden_b),
    .q_b       (q_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Advance past one rising edge; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wren_a = 1'b0; rden_a = 1'b0; wren_b = 1'b0; rden_b = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    address_a = '0; data_a = '0; wren_a = 1'b0; rden_a = 1'b1;
    address_b = '0; data_b = '0; wren_b = 1'b0; rden_b = 1'b1;

    // Reset with reads requested: outputs stay zero
    repeat (3) tick();
    check("rst_q_a", q_a, 32'h0);
    check("rst_q_b", q_b, 32'h0);

    // Release and read power-up contents of word 0
    rst_n = 1'b1;
    idle(); rden_a = 1'b1; address_a = 12'h000;
    tick();
    check("pwrup_q_a", q_a, 32'h0);

    // Basic write on A, read on B then A
    idle(); wren_a = 1'b1; address_a = 12'h005; data_a = 32'hDEADBEEF;
    tick();
    idle(); rden_b = 1'b1; address_b = 12'h005;
    tick();
    check("basic_q_b", q_b, 32'hDEADBEEF);
    idle(); rden_a = 1'b1; address_a = 12'h005;
    tick();
    check("basic_q_a", q_a, 32'hDEADBEEF);

    // Hold: A reads 0x11 from word 3, then B is busy elsewhere for 5 cycles
    idle(); wren_a = 1'b1; address_a = 12'h003; data_a = 32'h11;
    tick();
    idle(); rden_a = 1'b1; address_a = 12'h003;
    tick();
    check("hold_load_q_a", q_a, 32'h11);
    for (int i = 0; i < 5; i++) begin
      idle();
      address_a = 12'h005;
      wren_b = 1'b1; rden_b = 1'b1; address_b = 12'h040 + 12'(i); data_b = 32'hC0DE0000 + i;
      tick();
      check($sformatf("hold_q_a_%0d", i), q_a, 32'h11);
      check($sformatf("hold_rbw_q_b_%0d", i), q_b, 32'h0);
    end
    idle(); rden_b = 1'b1; address_b = 12'h042;
    tick();
    check("hold_b_wr", q_b, 32'hC0DE0002);

    // Same-port read-during-write returns the old word
    idle(); wren_a = 1'b1; address_a = 12'h007; data_a = 32'hAAAA0000;
    tick();
    idle(); wren_a = 1'b1; rden_a = 1'b1; address_a = 12'h007; data_a = 32'h12345678;
    tick();
    check("rdw_old_q_a", q_a, 32'hAAAA0000);
    idle(); rden_a = 1'b1; address_a = 12'h007;
    tick();
    check("rdw_new_q_a", q_a, 32'h12345678);

    // Both ports write 0xFFF: A's data wins
    idle();
    wren_a = 1'b1; address_a = 12'hFFF; data_a = 32'h1;
    wren_b = 1'b1; address_b = 12'hFFF; data_b = 32'h2;
    tick();
    idle(); rden_a = 1'b1; address_a = 12'hFFF; rden_b = 1'b1; address_b = 12'hFFF;
    tick();
    check("coll_q_a", q_a, 32'h1);
    check("coll_q_b", q_b, 32'h1);

    // A writes 0x10 while B reads it: B sees old, then new
    idle();
    wren_a = 1'b1; address_a = 12'h010; data_a = 32'h9;
    rden_b = 1'b1; address_b = 12'h010;
    tick();
    check("xrw_old_q_b", q_b, 32'h0);
    idle(); rden_b = 1'b1; address_b = 12'h010;
    tick();
    check("xrw_new_q_b", q_b, 32'h9);

    // Async reset mid-operation, with a write attempted during reset
    idle(); wren_a = 1'b1; address_a = 12'h020; data_a = 32'h55;
    tick();
    idle(); rden_a = 1'b1; address_a = 12'h020;
    tick();
    check("pre_rst_q_a", q_a, 32'h55);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_q_a", q_a, 32'h0);
    check("async_q_b", q_b, 32'h0);
    idle(); wren_a = 1'b1; rden_a = 1'b1; address_a = 12'h020; data_a = 32'hBAD;
    tick();
    check("in_rst_q_a", q_a, 32'h0);
    rst_n = 1'b1;
    idle(); rden_a = 1'b1; address_a = 12'h020;
    tick();
    check("post_rst_q_a", q_a, 32'h55);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
